// File: rtl/lsu_align.sv
// Load/store alignment unit between the MIPS execute stage and the data bus.
// Computes the effective address, issues one or two word-bus beats through a
// req/ack handshake, and aligns/extends/merges load data or positions store
// data and byte enables. Little-endian: byte offset 0 is bits 7:0.
module lsu_align #(
  parameter int unsigned ADDR_W    = 32,
  parameter bit          UNALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_rw_i,
  input  logic [2:0]        req_func_i,
  input  logic [ADDR_W-1:0] req_base_i,
  input  logic [15:0]       req_offset_i,
  input  logic [31:0]       req_rin_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              resp_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [2:0] F_B  = 3'b000, F_H  = 3'b001, F_WL = 3'b010, F_W  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_WR = 3'b110, F_UI = 3'b111;
  localparam logic [ADDR_W-3:0] WADDR_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  function automatic logic is_half(input logic [2:0] f);
    return f[1:0] == 2'b01;
  endfunction

  function automatic logic is_word(input logic [2:0] f);
    return f == F_W;
  endfunction

  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] k);
    return (is_half(f) && k[0]) || (is_word(f) && k != 2'd0);
  endfunction

  function automatic logic crosses(input logic [2:0] f, input logic [1:0] k);
    return (is_half(f) && k == 2'd3) || (is_word(f) && k != 2'd0);
  endfunction

  // First (or only) store beat. The default covers swr and the low half of a
  // word-crossing split, which share the same "shift up by k bytes" shape.
  function automatic beat_t store_first(input logic [2:0] f, input logic [1:0] k,
                                        input logic [31:0] rin);
    beat_t b;
    b.be    = 4'b1111 << k;
    b.wdata = rin << {k, 3'b000};
    case (f)
      F_B: begin
        b.be    = 4'b0001 << k;
        b.wdata = {4{rin[7:0]}};
      end
      F_H: if (k != 2'd3) begin
        b.be    = 4'b0011 << k;
        // An odd, non-crossing halfword needs the data in lanes 2:1.
        b.wdata = k[0] ? (rin << 8) : {2{rin[15:0]}};
      end
      F_WL: begin
        b.be    = (4'b0010 << k) - 4'd1;
        b.wdata = rin >> {2'd3 - k, 3'b000};
      end
      default: ;
    endcase
    return b;
  endfunction

  // Second beat of a crossing store: the bytes that spilled into word A+1.
  function automatic beat_t store_second(input logic [2:0] f, input logic [1:0] k,
                                         input logic [31:0] rin);
    beat_t b;
    b.be    = is_word(f) ? ((4'b0001 << k) - 4'd1) : 4'b0001;
    b.wdata = rin >> {3'd4 - {1'b0, k}, 3'b000};
    return b;
  endfunction

  // d64 holds {word A+1, word A}; for single beats both halves are the same word.
  function automatic logic [31:0] load_result(input logic [2:0] f, input logic [1:0] k,
                                              input logic [63:0] d64, input logic [31:0] rin);
    logic [31:0] s;
    logic [31:0] lo;
    logic [31:0] r;
    s  = 32'(d64 >> {k, 3'b000});
    lo = d64[31:0];
    case (f)
      F_B:     r = {{24{s[7]}}, s[7:0]};
      F_BU:    r = {24'h0, s[7:0]};
      F_H:     r = {{16{s[15]}}, s[15:0]};
      F_HU:    r = {16'h0, s[15:0]};
      F_W:     r = s;
      F_WL:    r = (lo << {2'd3 - k, 3'b000})
                 | (rin & (32'hffff_ffff >> {{1'b0, k} + 3'd1, 3'b000}));
      F_WR:    r = (lo >> {k, 3'b000}) | (rin & ~(32'hffff_ffff >> {k, 3'b000}));
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [2:0]        func_q, func_d;
  logic              rw_q, rw_d;
  logic [31:0]       rin_q, rin_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [ADDR_W-1:0] ea;
  logic [1:0]        k_q;
  logic [ADDR_W-3:0] a_q;
  logic              illegal;
  logic              lui;
  beat_t             first_beat;
  beat_t             second_beat;

  assign ea          = req_base_i + {{(ADDR_W-16){req_offset_i[15]}}, req_offset_i};
  assign k_q         = ea_q[1:0];
  assign a_q         = ea_q[ADDR_W-1:2];
  assign illegal     = req_rw_i && (req_func_i inside {F_BU, F_HU, F_UI});
  assign lui         = !req_rw_i && (req_func_i == F_UI);
  assign first_beat  = store_first(req_func_i, ea[1:0], req_rin_i);
  assign second_beat = store_second(func_q, k_q, rin_q);

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;

  // Next-state and datapath decisions for the IDLE/BEAT0/BEAT1/RESP sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a hold value first so no path can infer a latch.
    state_d     = state_q;
    ea_d        = ea_q;
    func_d      = func_q;
    rw_d        = rw_q;
    rin_d       = rin_q;
    rdata0_d    = rdata0_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        ea_d   = ea;
        func_d = req_func_i;
        rw_d   = req_rw_i;
        rin_d  = req_rin_i;
        if (illegal || (!UNALIGNED && misaligned(req_func_i, ea[1:0]))) begin
          state_d     = RESP;
          resp_err_d  = 1'b1;
          resp_data_d = 32'h0;
        end else if (lui) begin
          state_d     = RESP;
          resp_data_d = {req_offset_i, 16'h0};
        end else begin
          state_d     = BEAT0;
          mem_req_d   = 1'b1;
          mem_we_d    = req_rw_i;
          mem_addr_d  = ea[ADDR_W-1:2];
          mem_be_d    = req_rw_i ? first_beat.be : 4'b1111;
          mem_wdata_d = req_rw_i ? first_beat.wdata : 32'h0;
        end
      end
      BEAT0: if (mem_ack_i) begin
        mem_req_d = 1'b0;
        if (crosses(func_q, k_q)) begin
          // Request drops for one cycle while the second beat is set up.
          state_d    = BEAT1;
          rdata0_d   = mem_rdata_i;
          mem_addr_d = a_q + WADDR_ONE;
          if (rw_q) begin
            mem_be_d    = second_beat.be;
            mem_wdata_d = second_beat.wdata;
          end
        end else begin
          state_d     = RESP;
          resp_data_d = rw_q ? 32'h0
                             : load_result(func_q, k_q, {mem_rdata_i, mem_rdata_i}, rin_q);
        end
      end
      BEAT1: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack_i) begin
          mem_req_d   = 1'b0;
          state_d     = RESP;
          resp_data_d = rw_q ? 32'h0
                             : load_result(func_q, k_q, {mem_rdata_i, rdata0_q}, rin_q);
        end
      end
      RESP: begin
        state_d     = IDLE;
        resp_data_d = 32'h0;
        resp_err_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ea_q        <= '0;
      func_q      <= 3'b000;
      rw_q        <= 1'b0;
      rin_q       <= 32'h0;
      rdata0_q    <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      ea_q        <= ea_d;
      func_q      <= func_d;
      rw_q        <= rw_d;
      rin_q       <= rin_d;
      rdata0_q    <= rdata0_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed self-checking bench for lsu_align: alignment, extension, lwl/lwr
// merging, split beats, address wrap, lui, illegal ops, wait states and reset.
module tb_lsu_align;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_valid_u0, req_rw;
  logic [2:0]  req_func;
  logic [31:0] req_base, req_rin;
  logic [15:0] req_offset;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  logic        u0_req_ready, u0_resp_valid, u0_resp_err, u0_mem_req, u0_mem_we;
  logic [31:0] u0_resp_data, u0_mem_wdata;
  logic [29:0] u0_mem_addr;
  logic [3:0]  u0_mem_be;

  lsu_align #(.ADDR_W(32), .UNALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_func_i(req_func), .req_base_i(req_base), .req_offset_i(req_offset),
    .req_rin_i(req_rin), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  lsu_align #(.ADDR_W(32), .UNALIGNED(1'b0)) dut_u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_u0), .req_ready_o(u0_req_ready), .req_rw_i(req_rw),
    .req_func_i(req_func), .req_base_i(req_base), .req_offset_i(req_offset),
    .req_rin_i(req_rin), .resp_valid_o(u0_resp_valid), .resp_data_o(u0_resp_data),
    .resp_err_o(u0_resp_err), .mem_req_o(u0_mem_req), .mem_we_o(u0_mem_we),
    .mem_addr_o(u0_mem_addr), .mem_be_o(u0_mem_be), .mem_wdata_o(u0_mem_wdata),
    .mem_ack_i(1'b0), .mem_rdata_i(32'h0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Bus model state.
  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] dflt_rdata = 32'h0;
  int          wait_cnt   = 0;
  int          acks_left  = 1000;
  logic        req_seen   = 1'b0;
  int          log_n      = 0;
  logic [29:0] log_addr  [4];
  logic [3:0]  log_be    [4];
  logic [31:0] log_wdata [4];
  logic        log_we    [4];

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  logic [31:0] lb_exp  [4] = '{32'hfffffff0, 32'h00000045, 32'h00000002, 32'hfffffff1};
  logic [31:0] lwl_exp [4] = '{32'h44bbccdd, 32'h3344ccdd, 32'h223344dd, 32'h11223344};
  logic [31:0] lwr_exp [4] = '{32'h11223344, 32'haa112233, 32'haabb1122, 32'haabbcc11};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: acks a pending request after wait_cnt cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (mem_req) begin
        req_seen = 1'b1;
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else if (acks_left > 0) begin
          acks_left--;
          mem_ack   = 1'b1;
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : dflt_rdata;
          if (log_n < 4) begin
            log_addr[log_n]  = mem_addr;
            log_be[log_n]    = mem_be;
            log_wdata[log_n] = mem_wdata;
            log_we[log_n]    = mem_we;
          end
          log_n++;
        end
      end
    end
  end

  // Present one request; returns 1 ns after the accepting edge.
  task automatic send(input logic rw, input logic [2:0] f, input logic [31:0] base,
                      input logic [15:0] off, input logic [31:0] rin);
    req_rw     = rw;
    req_func   = f;
    req_base   = base;
    req_offset = off;
    req_rin    = rin;
    log_n      = 0;
    req_seen   = 1'b0;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Latency n = index of the edge (after acceptance) that first sees resp_valid.
  task automatic wait_resp(input int start, output logic [31:0] d, output logic e,
                           output int lat);
    int n;
    n = start;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_arrived", resp_valid, 1'b1);
    d   = resp_data;
    e   = resp_err;
    lat = n;
    @(posedge clk);
    #1;
    check("resp_one_cycle_ready", {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic xact(input logic rw, input logic [2:0] f, input logic [31:0] base,
                      input logic [15:0] off, input logic [31:0] rin);
    send(rw, f, base, off, rin);
    wait_resp(1, r_data, r_err, r_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_valid_u0 = 1'b0;
    req_rw       = 1'b0;
    req_func     = 3'b000;
    req_base     = 32'h0;
    req_offset   = 16'h0;
    req_rin      = 32'h0;
    mem_model[30'h40] = 32'h44332211;
    mem_model[30'h41] = 32'h88776655;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values.
    check("rst_ctrl", {req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be}, 9'b1_0000_0000);
    check("rst_data", {resp_data, mem_wdata}, 64'h0);
    check("rst_addr", mem_addr, 30'h0);

    // lb at k=0..3, base 4.
    dflt_rdata = 32'hf10245f0;
    for (int k = 0; k < 4; k++) begin
      xact(1'b0, 3'b000, 32'h4, 16'(k), 32'h0);
      check($sformatf("lb_k%0d", k), r_data, lb_exp[k]);
    end
    check("lb_lat", r_lat, 2);
    check("lb_addr", log_addr[0], 30'h1);
    xact(1'b0, 3'b101, 32'h4, 16'h2, 32'h0);
    check("lhu_k2", r_data, 32'h0000f102);
    xact(1'b0, 3'b001, 32'h4, 16'h2, 32'h0);
    check("lh_k2", r_data, 32'hfffff102);

    // lwl / lwr merging.
    dflt_rdata = 32'h11223344;
    for (int k = 0; k < 4; k++) begin
      xact(1'b0, 3'b010, 32'h0, 16'(k), 32'haabbccdd);
      check($sformatf("lwl_k%0d", k), r_data, lwl_exp[k]);
      xact(1'b0, 3'b110, 32'h0, 16'(k), 32'haabbccdd);
      check($sformatf("lwr_k%0d", k), r_data, lwr_exp[k]);
    end

    // Single-beat stores.
    xact(1'b1, 3'b000, 32'h10, 16'h2, 32'h000000a5);
    check("sb_beat", {log_n[3:0], log_we[0], log_addr[0], log_be[0], log_wdata[0]},
          {4'd1, 1'b1, 30'h4, 4'b0100, 32'ha5a5a5a5});
    check("sb_resp", {r_err, r_data}, 33'h0);
    xact(1'b1, 3'b010, 32'h10, 16'h1, 32'haabbccdd);
    check("swl_k1", {log_be[0], log_wdata[0]}, {4'b0011, 32'h0000aabb});
    xact(1'b1, 3'b110, 32'h10, 16'h2, 32'haabbccdd);
    check("swr_k2", {log_be[0], log_wdata[0]}, {4'b1100, 32'hccdd0000});

    // Illegal store flavour.
    xact(1'b1, 3'b100, 32'h10, 16'h0, 32'h12345678);
    check("ill_resp", {r_err, r_data}, {1'b1, 32'h0});
    check("ill_lat_nobus", {r_lat[7:0], req_seen}, {8'd1, 1'b0});

    // Split lw across words 0x40/0x41.
    xact(1'b0, 3'b011, 32'h100, 16'h2, 32'h0);
    check("split_lw_data", r_data, 32'h66554433);
    check("split_lw_lat", r_lat, 4);
    check("split_lw_addrs", {log_n[3:0], log_addr[0], log_addr[1]}, {4'd2, 30'h40, 30'h41});

    // Same access with UNALIGNED=0: immediate error, no bus request.
    req_rw       = 1'b0;
    req_func     = 3'b011;
    req_base     = 32'h100;
    req_offset   = 16'h2;
    req_valid_u0 = 1'b1;
    @(posedge clk);
    #1;
    req_valid_u0 = 1'b0;
    check("u0_err_resp", {u0_resp_valid, u0_resp_err, u0_resp_data, u0_mem_req},
          {1'b1, 1'b1, 32'h0, 1'b0});
    @(posedge clk);
    #1;
    check("u0_after", {u0_resp_valid, u0_req_ready, u0_mem_req}, 3'b010);

    // Split sh at EA 0x7.
    xact(1'b1, 3'b001, 32'h0, 16'h7, 32'h0000beef);
    check("split_sh_b0", {log_we[0], log_addr[0], log_be[0], log_wdata[0]},
          {1'b1, 30'h1, 4'b1000, 32'hef000000});
    check("split_sh_b1", {log_we[1], log_addr[1], log_be[1], log_wdata[1][7:0]},
          {1'b1, 30'h2, 4'b0001, 8'hbe});
    check("split_sh_lat", r_lat, 4);

    // Address wrap and lui.
    xact(1'b0, 3'b011, 32'hfffffffc, 16'h0004, 32'h0);
    check("wrap_up", log_addr[0], 30'h0);
    xact(1'b0, 3'b011, 32'hfffffffc, 16'hfffc, 32'h0);
    check("wrap_down", log_addr[0], 30'h3ffffffe);
    xact(1'b0, 3'b111, 32'h55555555, 16'h1234, 32'h0);
    check("lui_data", {r_err, r_data}, {1'b0, 32'h12340000});
    check("lui_lat_nobus", {r_lat[7:0], req_seen}, {8'd1, 1'b0});

    // Wait states: fields hold while ack is withheld.
    wait_cnt = 5;
    send(1'b1, 3'b011, 32'h20, 16'h0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wait_stable_%0d", i), {mem_req, mem_we, mem_addr, mem_be, mem_wdata},
            {1'b1, 1'b1, 30'h8, 4'hf, 32'h12345678});
      @(posedge clk);
      #1;
    end
    wait_resp(6, r_data, r_err, r_lat);
    check("wait_lat", r_lat, 7);

    // Reset during BEAT1: beat1 never acked.
    acks_left = 1;
    send(1'b0, 3'b011, 32'h100, 16'h2, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (log_n == 1 && mem_req) break;
      @(posedge clk);
      #1;
    end
    check("beat1_pending", {log_n == 1, mem_req}, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", {req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be}, 9'b1_0000_0000);
    check("arst_data", {resp_data, mem_wdata}, 64'h0);
    check("arst_addr", mem_addr, 30'h0);
    @(posedge clk);
    #1;
    check("arst_hold", {resp_valid, mem_req, req_ready}, 3'b001);
    rst_n     = 1'b1;
    acks_left = 1000;
    wait_cnt  = 0;
    @(posedge clk);
    #1;
    check("post_rst_idle", {resp_valid, mem_req, req_ready}, 3'b001);
    xact(1'b0, 3'b111, 32'h0, 16'habcd, 32'h0);
    check("post_rst_lui", r_data, 32'habcd0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
